layer_sequencer: RTL
====================

// Module: layer_sequencer
// PURPOSE
//  Top-level scheduler for the digit-recognition pipeline. Runs the per-layer memory
//  counters/addressers (conv1, pool1, conv2, pool2, fc) one at a time, in order.
//  For each stage it clears the counter, enables it, waits for its done flag, then moves on.
//  A per-stage watchdog flags a hung stage. Sits between the host/Avalon control regs and the
//  *_mem_read / *_mem_write counter blocks.
// PARAMETERS
//  NUM_STAGES  5      number of sequenced layers; stage 0 runs first
//  WDOG_W      16     width of the per-stage watchdog counter
//  TIMEOUT     40000  cycles allowed in RUN per stage before ERROR (must be < 2**WDOG_W)
// PORTS
//  clk         in   1           system clock
//  reset       in   1           asynchronous, active-high reset
//  start       in   1           1-cycle pulse: begin a run (honoured in IDLE, FINISH and ERROR)
//  abort       in   1           level: stop immediately, return to IDLE
//  stage_done  in   NUM_STAGES  done flags from the stage counters; sticky until cleared
//  stage_en    out  NUM_STAGES  one-hot enable to the active stage counter
//  stage_clr   out  NUM_STAGES  1-cycle clear pulse; drives the counter's reset input
//  cur_stage   out  $clog2(NUM_STAGES)  index of the active or last stage
//  busy        out  1           high in CLEAR, RUN and SETTLE
//  done        out  1           high in FINISH; held until the next start or abort
//  err         out  1           high in ERROR
//  err_stage   out  $clog2(NUM_STAGES)  stage that timed out; valid while err=1
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; idx=0; watchdog=0.
//  All outputs are registered. They are decoded from the next state, so they change on the
//  clock edge that enters the state.
//  States:
//   IDLE   -> CLEAR on start (idx<=0).
//   CLEAR  -> stage_clr[idx]=1 for exactly 1 cycle, stage_en=0, watchdog<=0; then RUN.
//   RUN    -> stage_en[idx]=1 and the watchdog increments.
//             stage_done[idx]=1: -> SETTLE.
//             watchdog==TIMEOUT-1 with no done: -> ERROR, err_stage<=idx.
//             The done-check takes priority over the timeout in the same cycle.
//   SETTLE -> 1 cycle with all enables low.
//             idx==NUM_STAGES-1: -> FINISH.
//             Otherwise: idx<=idx+1, -> CLEAR.
//   FINISH -> done=1. start: -> CLEAR with idx<=0.
//   ERROR  -> err=1, stage_en=0. start: -> CLEAR with idx<=0 (err cleared).
//  Latency: start to stage_clr[0] is 1 cycle. start to stage_en[0] is 2 cycles.
//  Per-stage overhead: 3 cycles (CLEAR, SETTLE, plus the done detect).
//  Done flags: stage_done bits other than [idx] are ignored in every state.
//   stage_done[idx] is ignored in CLEAR, because the stale sticky flag is being cleared.
//  abort (any state): next state IDLE; stage_en<=0; stage_clr<=all ones for 1 cycle;
//   done and err <=0. abort has priority over start and over all state transitions.
//  start while busy: ignored, with no effect on idx or the watchdog.
//  Watchdog saturates; it never wraps. idx never exceeds NUM_STAGES-1.
//  Async reset mid-run: everything returns to reset values immediately.
//   Counters are not pulsed; they share reset.
//  Invariants: stage_en is one-hot or zero. stage_en and stage_clr are never both nonzero.
// STRUCTURE
//  Package nn_seq_pkg:
//   - typedef enum logic [2:0] seq_state_t {IDLE, CLEAR, RUN, SETTLE, FINISH, ERROR}
//   - localparams STG_C1=0, STG_P1=1, STG_C2=2, STG_P2=3, STG_FC=4
//   - NUM_STAGES default
//  Sub-module stage_watchdog (clr, inc, limit -> expired): saturating counter of width
//   WDOG_W. It is cleared in CLEAR.
//  The FSM and one-hot decode live in layer_sequencer.
// TESTING
//  1. Nominal: reset, start. Each stage raises done 10 cycles after its enable.
//     -> clr/en visit stages 0..4 in order; done=1 at cycle 5*13+1; busy low after.
//  2. Stale done: hold stage_done=5'b11111 before start, with a model counter that drops done
//     on clr. -> no stage is skipped; each stage_en is high for >=1 cycle.
//  3. Timeout: TIMEOUT=20, stage 2 never finishes.
//     -> err=1 and err_stage=2 exactly 20 cycles after stage_en[2] rises; stage_en=0.
//     -> A following start restarts from stage 0 and clears err.
//  4. Abort during stage 3 RUN -> next cycle: IDLE, stage_en=0, stage_clr=5'b11111 for 1 cycle.
//     -> A later start runs the full sequence.
//  5. Ignored inputs: start pulses during RUN, and stage_done[4] asserted while idx=1.
//     -> no change in idx or timing versus scenario 1.
//  6. Async reset mid-SETTLE -> all outputs 0 before the next edge; FSM in IDLE.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the layer sequencer: FSM encoding, stage indices
// and a small state-classification helper.
package nn_seq_pkg;

    localparam int NUM_STAGES = 5;

    localparam int STG_C1 = 0;
    localparam int STG_P1 = 1;
    localparam int STG_C2 = 2;
    localparam int STG_P2 = 3;
    localparam int STG_FC = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        FINISH = 3'd4,
        ERROR  = 3'd5
    } seq_state_t;

    function automatic logic is_busy(input seq_state_t s);
        return (s == CLEAR) || (s == RUN) || (s == SETTLE);
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: saturating cycle counter that flags when it reaches the limit.
module stage_watchdog #(
    parameter int WDOG_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    input  logic [WDOG_W-1:0] limit,
    output logic              expired
);

    logic [WDOG_W-1:0] count;

    // Saturate rather than wrap so a hung stage can never look freshly started.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/layer_sequencer.sv
// Runs the per-layer counter blocks one at a time: clear, enable, wait for done, advance.
// Outputs are registered and decoded from the next state, so they change on the entering edge.
module layer_sequencer #(
    parameter int NUM_STAGES = nn_seq_pkg::NUM_STAGES,
    parameter int WDOG_W     = 16,
    parameter int TIMEOUT    = 40000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_en,
    output logic [NUM_STAGES-1:0]         stage_clr,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(NUM_STAGES)-1:0] err_stage,
    output logic [2:0]                    seq_state
);
    import nn_seq_pkg::*;

    localparam int                IDX_W = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_STAGES - 1);
    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [IDX_W-1:0]      err_stage_nxt;
    logic [NUM_STAGES-1:0] sel_nxt;
    logic                  wd_clr;
    logic                  wd_inc;
    logic                  expired;

    assign wd_clr = (state == CLEAR);
    assign wd_inc = (state == RUN);

    stage_watchdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .limit   (LIMIT),
        .expired (expired)
    );

    // start is a one-cycle request honoured only outside CLEAR/RUN/SETTLE; abort is a
    // level that overrides start and every transition, returning to IDLE.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        err_stage_nxt = err_stage;
        unique case (state)
            IDLE, FINISH, ERROR: begin
                if (start) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (stage_done[idx]) begin
                    state_nxt = SETTLE;
                end else if (expired) begin
                    state_nxt     = ERROR;
                    err_stage_nxt = idx;
                end
            end
            SETTLE: begin
                if (idx == LAST) begin
                    state_nxt = FINISH;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = CLEAR;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt     = IDLE;
            idx_nxt       = idx;
            err_stage_nxt = err_stage;
        end
        sel_nxt          = '0;
        sel_nxt[idx_nxt] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            err_stage <= '0;
            stage_en  <= '0;
            stage_clr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            err_stage <= err_stage_nxt;
            stage_en  <= (state_nxt == RUN) ? sel_nxt : '0;
            // abort pulses every counter's clear so no stage is left mid-count.
            stage_clr <= abort ? '1 : ((state_nxt == CLEAR) ? sel_nxt : '0);
            busy      <= is_busy(state_nxt);
            done      <= (state_nxt == FINISH);
            err       <= (state_nxt == ERROR);
        end
    end

    assign cur_stage = idx;
    assign seq_state = state;

endmodule
